// File: rtl/if_pkg.sv
// Shared widths, entry type and immediate sign-extension for the fetch stage.
// Optional perf counters in the top are enabled with IF_PERF_CNT_EN.
package if_pkg;

  localparam int PC_W_D       = 8;
  localparam int INSTR_W_D    = 16;
  localparam int OFS_W_D      = 6;
  localparam int FIFO_DEPTH_D = 4;
  localparam logic [PC_W_D-1:0] RESET_PC_D = '0;

  typedef struct packed {
    logic [PC_W_D-1:0]    pc;
    logic [INSTR_W_D-1:0] instr;
  } fetch_entry_t;

  // Sign-extend the low ofs_w bits of imm to 32 bits.
  function automatic logic [31:0] sext(
    input logic [31:0] imm,
    input int          ofs_w
  );
    logic [31:0] v;
    v = imm << (32 - ofs_w);
    return $signed(v) >>> (32 - ofs_w);
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Synchronous prefetch FIFO with flush, push/pop, occupancy and head read.
// Flush wins over any push or pop in the same cycle.
module if_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~i_flush;
  assign w_pop   = i_pop & ~i_flush & (r_count != '0);
  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  a_no_overflow: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    !(w_push && !w_pop && r_count == CW'(DEPTH))
  );

endmodule

// File: rtl/if_stage_prefetch.sv
// Fetch stage: PC gen, 1-cycle imem port, prefetch queue, redirect flush.
// Define IF_PERF_CNT_EN to add saturating fetch/flush counters.
module if_stage_prefetch
  import if_pkg::*;
#(
  parameter int              PC_W       = PC_W_D,
  parameter int              INSTR_W    = INSTR_W_D,
  parameter int              OFS_W      = OFS_W_D,
  parameter int              FIFO_DEPTH = FIFO_DEPTH_D,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(RESET_PC_D)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_en,
  input  logic                        branch_taken,
  input  logic                        jump,
  input  logic [OFS_W-1:0]            imm_offset,
  input  logic [PC_W-1:0]             br_base_pc,
  output logic                        imem_req,
  output logic [PC_W-1:0]             imem_addr,
  input  logic [INSTR_W-1:0]          imem_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PC_W-1:0]             out_pc,
  output logic [INSTR_W-1:0]          out_instr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]                 perf_fetch_cnt,
  output logic [15:0]                 perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CW1   = CNT_W + 1;
  localparam int E_W   = PC_W + INSTR_W;

  logic [PC_W-1:0]  r_fpc;
  logic [PC_W-1:0]  r_req_pc;
  logic             r_inflight;
  logic             w_redirect;
  logic             w_credit;
  logic             w_req;
  logic             w_push;
  logic             w_pop;
  logic [PC_W-1:0]  w_sext;
  logic [PC_W-1:0]  w_target;
  logic [E_W-1:0]   w_head;
  logic [CNT_W-1:0] w_count;

  assign w_redirect = jump | branch_taken;
  assign w_sext     = PC_W'(sext(32'(imm_offset), OFS_W));
  assign w_target   = jump ? w_sext
                           : br_base_pc + PC_W'(1) + w_sext;

  // Pop of this cycle is not credited so the request path stays short.
  assign w_credit = (CW1'(w_count) + CW1'(r_inflight)) < CW1'(FIFO_DEPTH);
  assign w_req    = rst & fetch_en & ~w_redirect & w_credit;

  assign imem_req  = w_req;
  assign imem_addr = r_fpc;

  assign w_push = r_inflight & ~w_redirect;
  assign w_pop  = out_valid & out_ready & ~w_redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fpc      <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_redirect) begin
        r_fpc <= w_target;
      end else if (w_req) begin
        r_fpc    <= r_fpc + PC_W'(1);
        r_req_pc <= r_fpc;
      end
    end
  end

  if_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (E_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_flush (w_redirect),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({r_req_pc, imem_rdata}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign fifo_count = w_count;
  assign out_valid  = (w_count != '0);
  assign {out_pc, out_instr} = out_valid ? w_head : '0;

`ifdef IF_PERF_CNT_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_push && r_fetch_cnt != 16'hFFFF)
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (w_redirect && r_flush_cnt != 16'hFFFF)
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule
